onehot_grant_decoder: RTL

- Reverse direction of the 8-input priority encoder: takes a 3-bit encoded index plus valid, and drives a registered one-hot grant vector.
- Each grant is held for a bounded time, followed by a mandatory gap.
- Sits between the priority encoder output and the eight requesting clients.
- Provides a ready/valid handshake, per-client enable masking, reject signalling and a grant counter.

---
 rtl/onehot_grant_decoder_pkg.sv | 33 +++
 rtl/onehot_grant_decoder_timer.sv | 28 ++
 rtl/onehot_grant_decoder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/onehot_grant_decoder_pkg.sv
// Shared types and helpers for the one-hot grant decoder and its neighbours.
package onehot_grant_decoder_pkg;

  // Controller state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Default geometry: 3-bit code selects one of 8 clients.
  localparam int unsigned DEF_CODE_W = 3;
  localparam int unsigned DEF_N      = 1 << DEF_CODE_W;

  // Widest client vector the helper below can produce.
  localparam int unsigned MAX_CODE_W = 8;
  localparam int unsigned MAX_N      = 1 << MAX_CODE_W;

  // One-hot from index for an n-client vector declared [0:n-1].
  // The result is right-aligned: cast it to n bits and assign it to a [0:n-1]
  // vector, and element idx is the one that is set. Out-of-range idx gives 0.
  function automatic logic [MAX_N-1:0] onehot_from_index(input int unsigned idx,
                                                         input int unsigned n);
    logic [MAX_N-1:0] oh;
    oh = '0;
    if (idx < n && n <= MAX_N) begin
      oh[0] = 1'b1;
      oh    = oh << (n - 1 - idx);
    end
    return oh;
  endfunction

endpackage

// File: rtl/onehot_grant_decoder_timer.sv
// Loadable down-counter shared by the grant-hold and inter-grant gap phases.
module grant_hold_timer #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load has priority over decrement; the count parks at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/onehot_grant_decoder.sv
// Encoded index -> registered one-hot grant with bounded hold, mandatory gap,
// per-client enable masking, reject pulse and a saturating grant counter.
module onehot_grant_decoder
  import onehot_grant_decoder_pkg::*;
#(
  parameter int unsigned CODE_W      = DEF_CODE_W,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [0:CODE_W-1] code,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic [0:(1<<CODE_W)-1] enable_mask,
  input  logic              done,
  output logic [0:(1<<CODE_W)-1] grant,
  output logic              busy,
  output logic              reject,
  output logic [0:CNT_W-1]  grant_count
);

  localparam int unsigned N = 1 << CODE_W;

  // One timer serves both phases, so it is sized for the longer of the two.
  localparam int unsigned TMR_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e           r_state;
  state_e           w_state_next;

  logic [0:N-1]     r_grant;
  logic             r_busy;
  logic             r_reject;
  logic [CNT_W-1:0] r_count;

  logic [0:N-1]     w_grant_next;
  logic             w_busy_next;
  logic             w_reject_next;
  logic [CNT_W-1:0] w_count_next;

  logic             w_accept;
  logic             w_code_ok;
  logic [0:N-1]     w_oh;

  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_load_val;
  logic             w_tmr_dec;
  logic             w_tmr_zero;

  assign code_ready = (r_state == ST_IDLE);
  assign w_accept   = code_valid && code_ready;
  // Mask is only consulted at accept; later changes never revoke a grant.
  assign w_code_ok  = enable_mask[code];
  assign w_oh       = N'(onehot_from_index(32'(code), N));

  grant_hold_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_load_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and timer control.
  always_comb begin
    w_state_next   = r_state;
    w_tmr_load     = 1'b0;
    w_tmr_load_val = '0;
    w_tmr_dec      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept && w_code_ok) begin
          w_state_next   = ST_GRANT;
          w_tmr_load     = 1'b1;
          w_tmr_load_val = HOLD_LOAD;
        end
      end
      ST_GRANT: begin
        // Early release and hold expiry share one exit path.
        if (done || w_tmr_zero) begin
          if (GAP_CYCLES > 0) begin
            w_state_next   = ST_GAP;
            w_tmr_load     = 1'b1;
            w_tmr_load_val = GAP_LOAD;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      ST_GAP: begin
        if (w_tmr_zero) begin
          w_state_next = ST_IDLE;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    w_grant_next  = r_grant;
    w_reject_next = 1'b0;
    w_count_next  = r_count;
    w_busy_next   = (w_state_next != ST_IDLE);
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_code_ok) begin
            w_grant_next = w_oh;
            if (r_count != '1) begin
              w_count_next = r_count + CNT_W'(1);
            end
          end else begin
            w_reject_next = 1'b1;
          end
        end
      end
      ST_GRANT: begin
        if (w_state_next != ST_GRANT) begin
          w_grant_next = '0;
        end
      end
      default: begin
        w_grant_next = '0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant  <= '0;
      r_busy   <= 1'b0;
      r_reject <= 1'b0;
      r_count  <= '0;
    end else begin
      r_grant  <= w_grant_next;
      r_busy   <= w_busy_next;
      r_reject <= w_reject_next;
      r_count  <= w_count_next;
    end
  end

  assign grant       = r_grant;
  assign busy        = r_busy;
  assign reject      = r_reject;
  assign grant_count = r_count;

endmodule
